// File: rtl/ime_pkg.sv
// Shared types and constants for the IME result output stage.
package ime_pkg;

  localparam int unsigned IME_SEQ_W = 16;
  localparam int unsigned IME_ACC_W = 32;

  localparam int unsigned IME_FLG_POISON = 0;
  localparam int unsigned IME_FLG_LAST   = 1;
  localparam int unsigned IME_FLG_SAT    = 2;

  // Tag fields placed above the accumulator in the packed output word.
  typedef struct packed {
    logic [IME_SEQ_W-1:0] seq;
    logic [7:0]           tuser;
    logic [7:0]           flags;
  } ime_result_hdr_t;

  typedef struct packed {
    logic [IME_SEQ_W-1:0] seq;
    logic [7:0]           tuser;
    logic [7:0]           flags;
    logic [IME_ACC_W-1:0] acc;
  } ime_result_word_t;

  function automatic logic [7:0] ime_make_flags(input logic poison, input logic last,
                                                input logic sat);
    logic [7:0] f;
    f                 = '0;
    f[IME_FLG_POISON] = poison;
    f[IME_FLG_LAST]   = last;
    f[IME_FLG_SAT]    = sat;
    return f;
  endfunction

endpackage

// File: rtl/ime_sync_fifo.sv
// Generic first-word-fall-through FIFO; occupancy held in its own counter.
module ime_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Callers guarantee push only when not full and pop only when not empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  // Empty reads as zero so the head word is clean out of reset.
  assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/ime_result_fifo.sv
// IME result output stage: tags beats with seq/flags and buffers them in a FWFT FIFO.
// Optional statistics outputs are enabled by defining IME_RESULT_STATS_EN.
module ime_result_fifo
  import ime_pkg::*;
#(
  parameter int unsigned W_ACC     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W_ACC-1:0]           s_axis_tdata,
  input  logic [7:0]                 s_axis_tuser,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       s_poison,
  input  logic                       flush,
  output logic [W_ACC+31:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
`ifdef IME_RESULT_STATS_EN
  output logic [15:0]                stat_drop_attempts,
  output logic [$clog2(DEPTH+1)-1:0] stat_max_fill,
`endif
  output logic                       almost_full,
  output logic [IME_SEQ_W-1:0]       seq_num
);

  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned FIFO_W = W_ACC + 33;

  logic                 push, pop;
  logic [CNT_W-1:0]     fill_d;
  logic [IME_SEQ_W-1:0] seq_q;
  logic                 af_q;
  ime_result_hdr_t      hdr;
  logic [FIFO_W-1:0]    wdata, rdata;

  assign s_axis_tready = (fill_level < CNT_W'(DEPTH)) && !flush;
  assign m_axis_tvalid = (fill_level != '0);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign hdr = '{seq:   seq_q,
                 tuser: s_axis_tuser,
                 flags: ime_make_flags(s_poison, s_axis_tlast, &s_axis_tdata)};

  // tlast rides in the MSB of the stored entry, outside the packed result word.
  assign wdata = {s_axis_tlast, hdr, s_axis_tdata};
  assign {m_axis_tlast, m_axis_tdata} = rdata;

  ime_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (fill_level)
  );

  always_comb begin
    fill_d = fill_level;
    if (flush) begin
      fill_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   fill_d = fill_level + CNT_W'(1);
        2'b01:   fill_d = fill_level - CNT_W'(1);
        default: fill_d = fill_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= '0;
      af_q  <= 1'b0;
    end else begin
      af_q <= (fill_d >= CNT_W'(DEPTH - AF_MARGIN));
      if (flush) begin
        seq_q <= '0;
      end else if (push && s_axis_tlast) begin
        seq_q <= seq_q + IME_SEQ_W'(1);
      end
    end
  end

  assign seq_num     = seq_q;
  assign almost_full = af_q;

`ifdef IME_RESULT_STATS_EN
  logic [15:0]      drop_q;
  logic [CNT_W-1:0] max_fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q     <= '0;
      max_fill_q <= '0;
    end else if (flush) begin
      drop_q     <= '0;
      max_fill_q <= '0;
    end else begin
      if (s_axis_tvalid && !s_axis_tready && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (fill_d > max_fill_q) max_fill_q <= fill_d;
    end
  end

  assign stat_drop_attempts = drop_q;
  assign stat_max_fill      = max_fill_q;
`endif

endmodule
